channels_encoder: RTL and testbench



---
 rtl/channels_encoder.sv | 127 ++++++++++++
 tb/tb_channels_encoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/channels_encoder.sv
// Multi-channel RC-style PWM generator. Signed commands are double-buffered
// behind a valid/ready handshake and take effect only at frame boundaries.
module channels_encoder #(
  parameter int K_NCHAN  = 4,
  parameter int K_RES    = 10,
  parameter int K_PERIOD = 2000
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_timebase,
  input  logic                       i_enable,
  input  logic [K_NCHAN-1:0]         i_polarity,
  input  logic [K_NCHAN*K_RES-1:0]   i_values,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic [K_NCHAN-1:0]         o_channels,
  output logic                       o_frame_start,
  output logic                       o_running
);

  localparam int CW = $clog2(K_PERIOD);
  localparam logic [CW-1:0] LAST_TICK = CW'(K_PERIOD - 1);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // A frame must be long enough to hold the widest possible pulse.
  if (K_PERIOD <= 2**K_RES) begin : g_period_check
    $error("channels_encoder: K_PERIOD must exceed 2**K_RES");
  end

  logic [0:0]               state_q, state_d;
  logic [CW-1:0]            frame_cnt_q, frame_cnt_d;
  logic [K_NCHAN*K_RES-1:0] pending_q, pending_d;
  logic                     pending_valid_q, pending_valid_d;
  logic [K_NCHAN*K_RES-1:0] active_q, active_d;
  logic [K_NCHAN-1:0]       channels_q, channels_d;
  logic                     frame_start_q, frame_start_d;
  logic                     running_q, running_d;
  logic                     fs_evt;
  logic [K_NCHAN-1:0]       pulse;

  always_comb begin
    state_d         = state_q;
    frame_cnt_d     = frame_cnt_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    active_d        = active_q;
    running_d       = running_q;
    fs_evt          = 1'b0;
    case (state_q)
      S_IDLE: begin
        frame_cnt_d = '0;
        running_d   = 1'b0;
        if (i_enable && i_timebase) begin
          state_d   = S_RUN;
          running_d = 1'b1;
          fs_evt    = 1'b1;
        end
      end
      default: begin
        if (i_timebase) begin
          if (frame_cnt_q == LAST_TICK) begin
            frame_cnt_d = '0;
            if (i_enable) begin
              fs_evt = 1'b1;
            end else begin
              state_d   = S_IDLE;
              running_d = 1'b0;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + CW'(1);
          end
        end
      end
    endcase
    // The frame-start transfer takes priority; a write in that cycle is refused.
    if (fs_evt && pending_valid_q) begin
      active_d        = pending_q;
      pending_valid_d = 1'b0;
    end else if (i_valid && !pending_valid_q) begin
      pending_d       = i_values;
      pending_valid_d = 1'b1;
    end
  end

  for (genvar gi = 0; gi < K_NCHAN; gi++) begin : g_pulse
    logic [K_RES-1:0] code;
    assign code = {~active_d[gi*K_RES + K_RES-1], active_d[gi*K_RES +: K_RES-1]};
    assign pulse[gi] = (frame_cnt_d < CW'(code));
  end

  always_comb begin
    frame_start_d = fs_evt;
    channels_d    = i_polarity;
    if (state_d == S_RUN) begin
      channels_d = i_polarity ^ pulse;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q         <= S_IDLE;
      frame_cnt_q     <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      active_q        <= '0;
      channels_q      <= '0;
      frame_start_q   <= 1'b0;
      running_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      frame_cnt_q     <= frame_cnt_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      active_q        <= active_d;
      channels_q      <= channels_d;
      frame_start_q   <= frame_start_d;
      running_q       <= running_d;
    end
  end

  assign o_ready       = ~pending_valid_q;
  assign o_channels    = channels_q;
  assign o_frame_start = frame_start_q;
  assign o_running     = running_q;

endmodule

// File: tb/tb_channels_encoder.sv
// Scoreboard bench: accepted writes are queued with their accept cycle; a
// monitor measures each frame's per-channel high time and period.
module tb_channels_encoder;
  localparam int NCH    = 4;
  localparam int RES    = 10;
  localparam int PERIOD = 2000;
  localparam int DIV    = 2;
  localparam int FRAME_CLKS = PERIOD * DIV;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_timebase = 1'b0;
  logic             i_enable;
  logic [NCH-1:0]   i_polarity;
  logic [NCH*RES-1:0] i_values;
  logic             i_valid;
  logic             o_ready;
  logic [NCH-1:0]   o_channels;
  logic             o_frame_start;
  logic             o_running;

  channels_encoder #(.K_NCHAN(NCH), .K_RES(RES), .K_PERIOD(PERIOD)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_timebase(i_timebase),
    .i_enable(i_enable), .i_polarity(i_polarity), .i_values(i_values),
    .i_valid(i_valid), .o_ready(o_ready), .o_channels(o_channels),
    .o_frame_start(o_frame_start), .o_running(o_running)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge i_clk);
      i_timebase = (cyc % DIV == 0);
    end
  end

  typedef struct {
    int               cyc;
    logic [NCH*RES-1:0] vals;
  } acc_t;

  acc_t acc_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   model_active[NCH];
  int   hi[NCH];
  int   fs_cyc   = 0;
  int   n_frames = 0;
  bit   in_frame = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: frames are delimited by o_frame_start and by o_running falling.
  initial begin
    logic [RES-1:0] tmp;
    for (int i = 0; i < NCH; i++) model_active[i] = 0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        in_frame = 0;
        acc_q.delete();
        for (int i = 0; i < NCH; i++) model_active[i] = 0;
      end else begin
        if (in_frame && (o_frame_start || !o_running)) begin
          for (int i = 0; i < NCH; i++)
            check($sformatf("frame%0d_ch%0d_high_clks", n_frames, i), hi[i],
                  (model_active[i] + 2**(RES-1)) * DIV);
          check($sformatf("frame%0d_period_clks", n_frames), cyc - fs_cyc, FRAME_CLKS);
          $display("frame %0d: high clks %0d %0d %0d %0d, length %0d", n_frames,
                   hi[0], hi[1], hi[2], hi[3], cyc - fs_cyc);
          in_frame = 0;
        end
        if (o_frame_start) begin
          check("running_at_frame_start", int'(o_running), 1);
          while (acc_q.size() > 0 && acc_q[0].cyc < cyc) begin
            for (int i = 0; i < NCH; i++) begin
              tmp = acc_q[0].vals[i*RES +: RES];
              model_active[i] = int'($signed(tmp));
            end
            void'(acc_q.pop_front());
          end
          fs_cyc = cyc;
          in_frame = 1;
          n_frames++;
          for (int i = 0; i < NCH; i++) hi[i] = 0;
        end
        if (in_frame)
          for (int i = 0; i < NCH; i++)
            if (o_channels[i] ^ i_polarity[i]) hi[i]++;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic wait_fs();
    int t = 0;
    do begin
      @(negedge i_clk);
      t++;
    end while (!o_frame_start && t < 3 * FRAME_CLKS);
    if (!o_frame_start) check("frame_start_timeout", 0, 1);
  endtask

  task automatic write(input logic [NCH*RES-1:0] vals, output int acc_cyc);
    int t = 0;
    acc_t e;
    acc_cyc = -1;
    @(negedge i_clk);
    i_values = vals;
    i_valid  = 1'b1;
    while (t < 3 * FRAME_CLKS) begin
      if (o_ready) begin
        acc_cyc = cyc + 1;
        e.cyc = acc_cyc;
        e.vals = vals;
        acc_q.push_back(e);
        @(negedge i_clk);
        break;
      end
      @(negedge i_clk);
      t++;
    end
    i_valid = 1'b0;
    if (acc_cyc < 0) check("write_accept_timeout", 0, 1);
    else $display("write %h accepted at cycle %0d", vals, acc_cyc);
  endtask

  function automatic logic [NCH*RES-1:0] rand_vals();
    logic [NCH*RES-1:0] v;
    for (int i = 0; i < NCH; i++) v[i*RES +: RES] = RES'($urandom_range(0, 2**RES - 1));
    return v;
  endfunction

  initial begin
    int acc;
    int nfs;
    i_rst_n = 1'b0; i_enable = 1'b0; i_valid = 1'b0;
    i_values = '0; i_polarity = 4'b1010;
    wait_cyc(3);
    check("reset_channels", int'(o_channels), 0);
    check("reset_running", int'(o_running), 0);
    check("reset_frame_start", int'(o_frame_start), 0);
    check("reset_ready", int'(o_ready), 1);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("first_clock_polarity", int'(o_channels), 4'b1010);
    i_polarity = 4'b0000;
    i_enable = 1'b1;

    wait_fs();            // F1 neutral
    wait_fs();            // F2 neutral
    wait_cyc(1000);
    write({10'h3FF, 10'h000, 10'h1FF, 10'h200}, acc);
    wait_fs();            // F3 extremes
    wait_cyc(500);
    write(rand_vals(), acc);  // A
    check("ready_low_with_pending", int'(o_ready), 0);
    wait_cyc(500);
    check("ready_still_low", int'(o_ready), 0);
    write(rand_vals(), acc);  // B, held until after F4 start
    check("b_accept_after_transfer", acc, fs_cyc + 1);
    wait_fs();            // F5 = B
    wait_cyc(300);
    write(rand_vals(), acc);
    wait_fs();            // F6
    wait_cyc(300);
    write(rand_vals(), acc);
    wait_fs();            // F7, enable dropped at tick 300
    wait_cyc(300 * DIV - 1);
    i_enable = 1'b0;
    nfs = 0;
    while (o_running && nfs < 2 * FRAME_CLKS) begin
      @(negedge i_clk);
      nfs++;
    end
    check("running_drops_after_frame", int'(o_running), 0);
    check("idle_channels_after_drop", int'(o_channels), 0);
    nfs = 0;
    repeat (1000) begin
      @(negedge i_clk);
      if (o_frame_start) nfs++;
    end
    check("no_frame_start_when_idle", nfs, 0);

    i_polarity = 4'b0101;
    write({4{10'd100}}, acc);
    check("idle_at_polarity", int'(o_channels), 4'b0101);
    i_enable = 1'b1;
    wait_fs();            // F8 inverted ch0/ch2, code 612
    wait_cyc(300);
    write(rand_vals(), acc);
    wait_fs();            // F9, reset at tick 200
    wait_cyc(100);
    write(rand_vals(), acc);
    wait_cyc(300);
    #1 i_rst_n = 1'b0;
    #1;
    check("async_reset_channels", int'(o_channels), 0);
    check("async_reset_running", int'(o_running), 0);
    i_enable = 1'b0;
    i_polarity = 4'b0000;
    wait_cyc(3);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("ready_after_reset", int'(o_ready), 1);
    i_enable = 1'b1;
    wait_fs();            // F10 neutral again
    wait_fs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
